// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the operation encoding, the sequencer states and the iteration count.
// Optional build macro used by the unit: MULDIV_EARLY_OUT_EN (multiply early exit).
package muldiv_pkg;

    // One radix-2 step per bit of a 32-bit operand
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    // Operation encoding as presented on the op port
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // True for the two divide operations
    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // True for the two operations that treat operands as two's complement
    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation used when signs are re-applied
// to magnitude results (64-bit product, 32-bit quotient and remainder).
// Optional build macro in this slice: MULDIV_EARLY_OUT_EN (not used here).
module muldiv_signfix #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Pass the magnitude through, or return its two's complement
    always_comb begin
        result = value;
        if (negate) begin
            result = (~value) + WIDTH'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes on accept, processed one bit per cycle
// (shift-add multiply, restoring divide), and signs are re-applied in FIX
// before the single HI/LO write. Normal latency is 32 ITER + 1 FIX cycles.
// Build macro MULDIV_EARLY_OUT_EN: multiplies leave ITER as soon as the
// remaining multiplier bits are all zero (at least one ITER cycle).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int PW = 2 * XLEN;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div_q;
    logic             div0_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [XLEN-1:0]  mplier;

    op_e              op_in;
    logic             in_div;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             b_zero;

    logic [PW-1:0]    mul_acc_next;
    logic [XLEN:0]    div_shift;
    logic [XLEN-1:0]  div_sub;
    logic             div_ge;
    logic [PW-1:0]    div_acc_next;
    logic             cnt_last;
    logic             mul_last;

    logic [PW-1:0]    prod_fix;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;

    // Decode the incoming request and form operand magnitudes and signs
    always_comb begin
        op_in     = op_e'(op);
        in_div    = op_is_div(op_in);
        in_signed = op_is_signed(op_in);
        a_neg     = in_signed & a[XLEN-1];
        b_neg     = in_signed & b[XLEN-1];
        a_mag     = a_neg ? ((~a) + XLEN'(1)) : a;
        b_mag     = b_neg ? ((~b) + XLEN'(1)) : b;
        b_zero    = (b == '0);
    end

    // One radix-2 step of each algorithm, plus the ITER exit conditions
    always_comb begin
        mul_acc_next = mplier[0] ? (acc + mcand) : acc;

        div_shift    = {acc[PW-1:XLEN], acc[XLEN-1]};
        div_ge       = (div_shift >= {1'b0, mcand[XLEN-1:0]});
        div_sub      = div_shift[XLEN-1:0] - mcand[XLEN-1:0];
        if (div_ge) begin
            div_acc_next = {div_sub, acc[XLEN-2:0], 1'b1};
        end else begin
            div_acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end

        cnt_last = (cnt == CNT_W'(ITER_COUNT - 1));
        mul_last = cnt_last;
`ifdef MULDIV_EARLY_OUT_EN
        if (mplier[XLEN-1:1] == '0) begin
            mul_last = 1'b1;
        end
`else
        mul_last = cnt_last;
`endif
    end

    muldiv_signfix #(.WIDTH(PW)) u_fix_prod (
        .value  (acc),
        .negate (neg_q),
        .result (prod_fix)
    );

    muldiv_signfix #(.WIDTH(XLEN)) u_fix_quo (
        .value  (acc[XLEN-1:0]),
        .negate (neg_q),
        .result (quo_fix)
    );

    muldiv_signfix #(.WIDTH(XLEN)) u_fix_rem (
        .value  (acc[PW-1:XLEN]),
        .negate (rem_neg_q),
        .result (rem_fix)
    );

    // Sequencer, datapath registers and registered HI/LO/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div0      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ITER;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        is_div_q  <= in_div;
                        div0_q    <= in_div & b_zero;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        mplier    <= b_mag;
                        if (in_div) begin
                            mcand <= {{XLEN{1'b0}}, b_mag};
                            if (b_zero) begin
                                acc <= {a_mag, {XLEN{1'b0}}};
                            end else begin
                                acc <= {{XLEN{1'b0}}, a_mag};
                            end
                        end else begin
                            mcand <= {{XLEN{1'b0}}, a_mag};
                            acc   <= '0;
                        end
                    end else begin
                        if (mthi) begin
                            hi <= wdata;
                        end
                        if (mtlo) begin
                            lo <= wdata;
                        end
                    end
                end

                ST_ITER: begin
                    if (div0_q) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (is_div_q) begin
                            acc <= div_acc_next;
                            if (cnt_last) begin
                                state <= ST_FIX;
                            end
                        end else begin
                            acc    <= mul_acc_next;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                            if (mul_last) begin
                                state <= ST_FIX;
                            end
                        end
                    end
                end

                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    div0  <= div0_q;
                    if (is_div_q) begin
                        hi <= rem_fix;
                        lo <= div0_q ? {XLEN{1'b1}} : quo_fix;
                    end else begin
                        hi <= prod_fix[PW-1:XLEN];
                        lo <= prod_fix[XLEN-1:0];
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
